// File: rtl/gen_scheduler.sv
// -----------------------------------------------------------------------------
// gen_scheduler
//
// Purpose:
//   Accepts packet metadata from a host, forwards it to one of four packet
//   generators, tracks how many packets each generator has queued, and
//   arbitrates round-robin among generators with pending packets. It drains
//   one packet at a time onto a shared 32-bit egress bus.
//
// Ports:
//   clk, reset       clock (rising edge) and synchronous active-high reset
//   host_wr          host metadata write strobe
//   host_port        target generator for host_wr
//   host_meta        metadata: [31:30] src, [29:28] dest, [27:22] len,
//                    [21:0] timestamp
//   host_full        per-port queue full (pending == PEND_MAX)
//   gen_meta_en      one-hot metadata write to generator i (combinational)
//   gen_meta         metadata to generators (shared)
//   gen_send_en      one-hot advance enable to the granted generator
//   gen_ready        generator i word valid
//   gen_data         generator i word at [32i+31:32i]
//   out_stall        downstream backpressure
//   out_valid/sop/eop, out_data, out_port   egress word and qualifiers
//   sent_cnt         per-port completed packet counters (GEN_SCHED_STATS_EN)
//
// Configuration:
//   GEN_SCHED_STATS_EN  when defined, adds the sent_cnt output and counters.
// -----------------------------------------------------------------------------
module gen_scheduler #(
    parameter int PEND_MAX   = 1023,
    parameter int META_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_wr,
    input  logic [1:0]            host_port,
    input  logic [META_WIDTH-1:0] host_meta,
    output logic [3:0]            host_full,
    output logic [3:0]            gen_meta_en,
    output logic [META_WIDTH-1:0] gen_meta,
    output logic [3:0]            gen_send_en,
    input  logic [3:0]            gen_ready,
    input  logic [127:0]          gen_data,
    input  logic                  out_stall,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [31:0]           out_data,
    output logic [1:0]            out_port
`ifdef GEN_SCHED_STATS_EN
    ,
    output logic [3:0][15:0]      sent_cnt
`endif
);

    localparam int CW = $clog2(PEND_MAX + 1);
    localparam int AW = (PEND_MAX > 1) ? $clog2(PEND_MAX) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARB  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          sop_pend_q, sop_pend_d;
    logic [CW-1:0] pend_q   [4];
    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [5:0]    len_mem  [4][PEND_MAX];

    logic          accept;
    logic          in_send;
    logic          advance;
    logic          pkt_end;
    logic          any_pend;
    logic [1:0]    arb_pick;
    logic [1:0]    rr_idx;
    logic          arb_found;
    logic [5:0]    head_len;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        if (ptr == AW'(PEND_MAX - 1)) begin
            return '0;
        end
        return ptr + AW'(1);
    endfunction

    // Host side: accept/drop decision and same-cycle forwarding to generators.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            host_full[p] = (pend_q[p] == CW'(PEND_MAX));
        end
    end

    assign accept      = host_wr & ~reset & ~host_full[host_port];
    assign gen_meta_en = accept ? (4'b0001 << host_port) : 4'b0000;
    assign gen_meta    = accept ? host_meta : '0;

    // Egress side: everything is qualified by SEND so idle outputs read zero.
    assign in_send     = (state_q == SEND);
    assign advance     = in_send & ~out_stall;
    assign pkt_end     = advance & (cnt_q == 7'd0);
    assign gen_send_en = advance ? (4'b0001 << grant_q) : 4'b0000;
    assign out_valid   = advance & gen_ready[grant_q];
    assign out_sop     = out_valid & sop_pend_q;
    assign out_eop     = pkt_end;
    assign out_data    = in_send ? gen_data[{grant_q, 5'd0} +: 32] : 32'd0;
    assign out_port    = in_send ? grant_q : 2'd0;

    always_comb begin
        any_pend = 1'b0;
        for (int p = 0; p < 4; p++) begin
            any_pend = any_pend | (pend_q[p] != '0);
        end
    end

    // Round-robin search starts one past the last grant; the fourth step lands
    // on the last grant itself so a lone busy port can be re-granted.
    always_comb begin
        arb_pick  = grant_q;
        arb_found = 1'b0;
        rr_idx    = grant_q;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = grant_q + 2'(i);
            if (!arb_found && (pend_q[rr_idx] != '0)) begin
                arb_pick  = rr_idx;
                arb_found = 1'b1;
            end
        end
    end

    assign head_len = len_mem[arb_pick][rd_ptr_q[arb_pick]];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        sop_pend_d = sop_pend_q;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                // Counter holds the remaining send cycles minus one, so a
                // packet occupies 8 + len unstalled cycles.
                grant_d    = arb_pick;
                cnt_d      = 7'd7 + {1'b0, head_len};
                sop_pend_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (out_valid) begin
                    sop_pend_d = 1'b0;
                end
                if (advance) begin
                    if (cnt_q == 7'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'd3;
            cnt_q      <= 7'd0;
            sop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            sop_pend_q <= sop_pend_d;
        end
    end

    // Pending counters and length FIFO pointers move together, so the FIFO
    // occupancy of a port always equals its pending count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                pend_q[p]   <= '0;
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                logic inc;
                logic dec;
                inc = accept && (host_port == 2'(p));
                dec = pkt_end && (grant_q == 2'(p));
                if (inc && !dec) begin
                    pend_q[p] <= pend_q[p] + CW'(1);
                end else if (dec && !inc) begin
                    pend_q[p] <= pend_q[p] - CW'(1);
                end
                if (inc) begin
                    wr_ptr_q[p] <= next_ptr(wr_ptr_q[p]);
                end
                if (dec) begin
                    rd_ptr_q[p] <= next_ptr(rd_ptr_q[p]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            len_mem[host_port][wr_ptr_q[host_port]] <= host_meta[27:22];
        end
    end

`ifdef GEN_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt <= '0;
        end else if (pkt_end) begin
            sent_cnt[grant_q] <= sent_cnt[grant_q] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gen_scheduler.sv
module tb_gen_scheduler;

    logic         clk;
    logic         reset;
    logic         host_wr;
    logic [1:0]   host_port;
    logic [31:0]  host_meta;
    logic [3:0]   host_full;
    logic [3:0]   gen_meta_en;
    logic [31:0]  gen_meta;
    logic [3:0]   gen_send_en;
    logic [3:0]   gen_ready;
    logic [127:0] gen_data;
    logic         out_stall;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic [31:0]  out_data;
    logic [1:0]   out_port;
`ifdef GEN_SCHED_STATS_EN
    logic [3:0][15:0] sent_cnt;
`endif

    gen_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .host_wr    (host_wr),
        .host_port  (host_port),
        .host_meta  (host_meta),
        .host_full  (host_full),
        .gen_meta_en(gen_meta_en),
        .gen_meta   (gen_meta),
        .gen_send_en(gen_send_en),
        .gen_ready  (gen_ready),
        .gen_data   (gen_data),
        .out_stall  (out_stall),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_data   (out_data),
        .out_port   (out_port)
`ifdef GEN_SCHED_STATS_EN
        ,
        .sent_cnt   (sent_cnt)
`endif
    );

    localparam int PEND_MAX = 1023;

    typedef struct {
        logic [1:0] port;
        int         len;
    } pkt_t;

    pkt_t sb[$];
    int   vectors = 0;
    int   errs    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] gword(input int p, input int n);
        return {8'hA0 + 8'(p), 8'h00, 16'(n)};
    endfunction

    // Generator model: each port presents a running word count that advances
    // only when the scheduler enables it.
    logic [15:0] wcnt [4];
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (reset) wcnt[p] <= 16'd0;
            else if (gen_send_en[p]) wcnt[p] <= wcnt[p] + 16'd1;
        end
    end
    always_comb begin
        gen_data = '0;
        for (int p = 0; p < 4; p++) gen_data[32*p +: 32] = gword(p, int'(wcnt[p]));
    end

    // Egress monitor: compares every completed packet with the scoreboard head.
    int mon_cyc;
    bit mon_seen;
    int exp_w [4];
    always @(negedge clk) begin
        if (reset) begin
            mon_cyc  = 0;
            mon_seen = 1'b0;
            for (int p = 0; p < 4; p++) exp_w[p] = 0;
        end else begin
            if (out_stall) chk("stall_quiet", 64'({gen_send_en, out_valid}), 64'd0);
            if (gen_send_en != 4'd0) begin
                chk("send_onehot", 64'(gen_send_en), 64'(4'b0001 << out_port));
                mon_cyc++;
            end
            if (out_valid) begin
                chk("data", 64'(out_data), 64'(gword(int'(out_port), exp_w[out_port])));
                chk("sop", 64'(out_sop), 64'(!mon_seen));
                exp_w[out_port]++;
                mon_seen = 1'b1;
            end
            if (out_eop) begin
                if (sb.size() == 0) begin
                    chk("unexpected_eop", 64'(out_port), 64'hFF);
                end else begin
                    pkt_t e;
                    e = sb.pop_front();
                    chk("grant_port", 64'(out_port), 64'(e.port));
                    chk("send_cycles", 64'(mon_cyc), 64'(8 + e.len));
                end
                mon_cyc  = 0;
                mon_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input int port, input int len, input bit acc);
        logic [31:0] meta;
        pkt_t e;
        meta = {2'(port), 2'(3 - port), 6'(len), 22'(vectors + 12345)};
        host_wr   = 1'b1;
        host_port = 2'(port);
        host_meta = meta;
        #1;
        chk("meta_en", 64'(gen_meta_en), acc ? 64'(4'b0001 << port) : 64'd0);
        if (acc) begin
            chk("meta", 64'(gen_meta), 64'(meta));
            e.port = 2'(port);
            e.len  = len;
            sb.push_back(e);
        end
        tick();
        host_wr = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({host_full, gen_meta_en, gen_send_en, out_valid, out_sop, out_eop, out_port}), 64'd0);
        chk(tag, {gen_meta, out_data}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int sc;
        reset     = 1'b1;
        host_wr   = 1'b0;
        host_port = 2'd0;
        host_meta = 32'd0;
        gen_ready = 4'hF;
        out_stall = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        reset = 1'b0;
        tick();
        chk_all_zero("idle_outputs");

        // Single len=0 packet on port 1.
        do_write(1, 0, 1'b1);
        wait_drain(100);

        // One len=2 packet per port, granted 0,1,2,3 from the reset grant.
        do_reset();
        for (int p = 0; p < 4; p++) do_write(p, 2, 1'b1);
        wait_drain(300);

        // Three stalled cycles in the payload of a len=6 packet.
        do_write(3, 6, 1'b1);
        n  = 0;
        sc = 0;
        while (sc < 9 && n < 100) begin
            tick();
            if (gen_send_en != 4'd0) sc++;
            n++;
        end
        chk("stall_reach", 64'(sc), 64'd9);
        out_stall = 1'b1;
        repeat (3) tick();
        out_stall = 1'b0;
        wait_drain(100);

        // Fill port 2 while egress is stalled, then overflow and drain one.
        out_stall = 1'b1;
        for (int i = 0; i < PEND_MAX; i++) do_write(2, 0, 1'b1);
        chk("full_set", 64'(host_full), 64'(4'b0100));
        do_write(2, 0, 1'b0);
        chk("full_hold", 64'(host_full), 64'(4'b0100));
        out_stall = 1'b0;
        n = 0;
        while (sb.size() > PEND_MAX - 1 && n < 50) begin
            tick();
            n++;
        end
        chk("one_drained", 64'(sb.size()), 64'(PEND_MAX - 1));
        chk("full_clear", 64'(host_full), 64'd0);

        // Reset in the middle of a packet.
        n = 0;
        while (gen_send_en == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("in_send", 64'(gen_send_en), 64'(4'b0100));
        reset = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        sb.delete();
        reset = 1'b0;
        tick();
        chk_all_zero("post_reset");
        repeat (4) tick();
        chk("post_reset_quiet", 64'({host_full, gen_send_en}), 64'd0);

        // Write to port 0 on its final send cycle; port 1 must go first.
        do_write(0, 1, 1'b1);
        do_write(1, 1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(out_eop && out_port == 2'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("eop_port0_seen", 64'({out_eop, out_port}), 64'({1'b1, 2'd0}));
        begin
            pkt_t e;
            host_wr   = 1'b1;
            host_port = 2'd0;
            host_meta = {2'd0, 2'd3, 6'd3, 22'h155};
            #1;
            chk("meta_en_at_eop", 64'(gen_meta_en), 64'(4'b0001));
            e.port = 2'd0;
            e.len  = 3;
            sb.push_back(e);
            @(posedge clk);
            #2;
            host_wr = 1'b0;
        end
        wait_drain(200);
        repeat (4) tick();
        chk("final_idle", 64'({host_full, gen_send_en}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
